// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapping a single-port-pair RAM: pointers, occupancy and a
// one-entry registered output stage that gives a first-word-registered FIFO.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int DEPTH       = 1024,
    parameter int AFULL_LEVEL = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic                  ram_write_enable,
    output logic                  ram_read_enable,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] rd_ptr_nxt;
    logic [ADDR_WIDTH:0]   mem_count;
    logic                  push;
    logic                  load;

    // Both sides use valid/ready: a word moves on a rising edge only when
    // valid and ready are both high; the sender holds valid and data stable
    // until then, and ready never depends combinationally on valid.
    assign full        = (mem_count == DEPTH_CNT);
    assign in_ready    = !full;
    assign push        = in_valid && in_ready;
    assign load        = (mem_count != '0) && (!out_valid || out_ready);

    assign level       = mem_count + {{ADDR_WIDTH{1'b0}}, out_valid};
    assign empty       = (level == '0);
    assign almost_full = (level >= AFULL_CNT);

    assign ram_write_enable = push;
    assign ram_write_addr   = wr_ptr;
    assign ram_data_in      = in_data;
    assign ram_read_enable  = load;
    assign ram_read_addr    = rd_ptr;

    // DEPTH need not be a power of two, so wrap explicitly at DEPTH-1.
    assign wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (load) begin
            rd_ptr <= rd_ptr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_count <= '0;
        end else begin
            case ({push, load})
                2'b10:   mem_count <= mem_count + 1'b1;
                2'b01:   mem_count <= mem_count - 1'b1;
                default: mem_count <= mem_count;
            endcase
        end
    end

    // rd_ptr == wr_ptr only when the RAM is empty (no load) or full (no
    // push), so the read never targets the word being written this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= ram_data_out;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a DEPTH=4 instance and a DEPTH=3 instance, each
// with a behavioural RAM, checked against a queue-based FIFO model.
module tb_ram_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       iv   [2];
  logic       ir   [2];
  logic [7:0] id   [2];
  logic       ov   [2];
  logic       ordy [2];
  logic [7:0] od   [2];
  logic [1:0] wa   [2];
  logic [1:0] ra   [2];
  logic       we   [2];
  logic       re   [2];
  logic [7:0] rdi  [2];
  logic [7:0] rdo  [2];
  logic [2:0] lv   [2];
  logic       fu   [2];
  logic       em   [2];
  logic       af   [2];

  logic [7:0] mem0 [4];
  logic [7:0] mem1 [4];

  int n_checks = 0;
  int n_fail   = 0;

  // model: every held word in order, whether the output register is loaded,
  // and how many words have ever been accepted
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         ov_m   [2];
  int         pushes [2];

  ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4), .AFULL_LEVEL(3)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .ram_write_addr(wa[0]), .ram_read_addr(ra[0]),
    .ram_write_enable(we[0]), .ram_read_enable(re[0]),
    .ram_data_in(rdi[0]), .ram_data_out(rdo[0]),
    .level(lv[0]), .full(fu[0]), .empty(em[0]), .almost_full(af[0])
  );

  ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(3), .AFULL_LEVEL(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .ram_write_addr(wa[1]), .ram_read_addr(ra[1]),
    .ram_write_enable(we[1]), .ram_read_enable(re[1]),
    .ram_data_in(rdi[1]), .ram_data_out(rdo[1]),
    .level(lv[1]), .full(fu[1]), .empty(em[1]), .almost_full(af[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural RAMs: synchronous write, combinational read
  always @(posedge clk) begin
    if (we[0]) mem0[wa[0]] <= rdi[0];
    if (we[1]) mem1[wa[1]] <= rdi[1];
  end
  assign rdo[0] = mem0[ra[0]];
  assign rdo[1] = mem1[ra[1]];

  // ---------------- model helpers ----------------
  function automatic int dep_of(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int afl_of(input int d);
    return (d == 0) ? 3 : 2;
  endfunction

  function automatic int msize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [7:0] mfront(input int d);
    if (msize(d) == 0) return 8'h00;
    return (d == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic mpush(input int d, input logic [7:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic mpop(input int d);
    if (d == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int d = 0; d < 2; d++) begin
      ov_m[d]   = 0;
      pushes[d] = 0;
    end
  endtask

  // ---------------- driver: one clock cycle on one instance ----------------
  // Drives inputs, compares every output against the model, steps the edge.
  // A word accepted at an edge becomes visible in the output register one
  // edge later, so the output register is loaded after an edge exactly when
  // some word that was already held before that edge is still held.
  task automatic cycle(input int d, input logic v, input logic [7:0] data, input logic rdy,
                       output logic acc, output logic popped, output logic [7:0] pword,
                       output logic [1:0] obs_wa);
    int   held;
    int   mem_n;
    int   pop_m;
    logic exp_rdy;
    logic exp_re;
    iv[d] = v; id[d] = data; ordy[d] = rdy;
    iv[1-d] = 1'b0; ordy[1-d] = 1'b0;
    #1;
    held    = msize(d);
    mem_n   = held - ov_m[d];
    exp_rdy = (mem_n < dep_of(d));
    exp_re  = (mem_n > 0) && (ov_m[d] == 0 || rdy);
    n_checks++;
    if (ir[d] !== exp_rdy) begin
      n_fail++; $display("FAIL in_ready dut%0d t=%0t: got %b exp %b", d, $time, ir[d], exp_rdy);
    end
    n_checks++;
    if (ov[d] !== (ov_m[d] != 0)) begin
      n_fail++; $display("FAIL out_valid dut%0d t=%0t: got %b exp %0d", d, $time, ov[d], ov_m[d]);
    end
    if (ov_m[d] != 0) begin
      n_checks++;
      if (od[d] !== mfront(d)) begin
        n_fail++; $display("FAIL out_data dut%0d t=%0t: got %h exp %h", d, $time, od[d], mfront(d));
      end
    end
    n_checks++;
    if (lv[d] !== 3'(held)) begin
      n_fail++; $display("FAIL level dut%0d t=%0t: got %0d exp %0d", d, $time, lv[d], held);
    end
    n_checks++;
    if (fu[d] !== (mem_n == dep_of(d))) begin
      n_fail++; $display("FAIL full dut%0d t=%0t: got %b exp %b", d, $time, fu[d], mem_n == dep_of(d));
    end
    n_checks++;
    if (em[d] !== (held == 0)) begin
      n_fail++; $display("FAIL empty dut%0d t=%0t: got %b exp %b", d, $time, em[d], held == 0);
    end
    n_checks++;
    if (af[d] !== (held >= afl_of(d))) begin
      n_fail++; $display("FAIL almost_full dut%0d t=%0t: got %b exp %b", d, $time, af[d], held >= afl_of(d));
    end
    n_checks++;
    if (we[d] !== (v && exp_rdy)) begin
      n_fail++; $display("FAIL ram_write_enable dut%0d t=%0t: got %b exp %b", d, $time, we[d], v && exp_rdy);
    end
    n_checks++;
    if (wa[d] !== 2'(pushes[d] % dep_of(d))) begin
      n_fail++; $display("FAIL ram_write_addr dut%0d t=%0t: got %0d exp %0d", d, $time, wa[d], pushes[d] % dep_of(d));
    end
    n_checks++;
    if (ra[d] !== 2'((pushes[d] - mem_n) % dep_of(d))) begin
      n_fail++; $display("FAIL ram_read_addr dut%0d t=%0t: got %0d exp %0d", d, $time, ra[d], (pushes[d] - mem_n) % dep_of(d));
    end
    n_checks++;
    if (re[d] !== exp_re) begin
      n_fail++; $display("FAIL ram_read_enable dut%0d t=%0t: got %b exp %b", d, $time, re[d], exp_re);
    end
    n_checks++;
    if (rdi[d] !== data) begin
      n_fail++; $display("FAIL ram_data_in dut%0d t=%0t: got %h exp %h", d, $time, rdi[d], data);
    end
    acc    = ir[d] && v;
    popped = ov[d] && rdy;
    pword  = od[d];
    obs_wa = wa[d];
    @(posedge clk);
    pop_m = (ov_m[d] != 0 && rdy) ? 1 : 0;
    if (pop_m != 0) mpop(d);
    if (v && exp_rdy) begin
      mpush(d, data);
      pushes[d]++;
    end
    ov_m[d] = ((held - pop_m) > 0) ? 1 : 0;
    #1;
  endtask

  task automatic check_idle_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (ir[d] !== 1'b1 || fu[d] !== 1'b0 || em[d] !== 1'b1 || lv[d] !== 3'd0 || af[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s flags dut%0d: got ready=%b full=%b empty=%b level=%0d afull=%b exp 1 0 1 0 0",
                 tag, d, ir[d], fu[d], em[d], lv[d], af[d]);
      end
      n_checks++;
      if (we[d] !== 1'b0 || re[d] !== 1'b0 || wa[d] !== 2'd0 || ra[d] !== 2'd0 || ov[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s ram_if dut%0d: got we=%b re=%b wa=%0d ra=%0d ov=%b exp 0 0 0 0 0",
                 tag, d, we[d], re[d], wa[d], ra[d], ov[d]);
      end
      n_checks++;
      if (rdi[d] !== id[d]) begin
        n_fail++; $display("FAIL %s ram_data_in dut%0d: got %h exp %h", tag, d, rdi[d], id[d]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; id[d] = 8'h5A;
    end
    model_reset();
    #2;
    check_idle_reset_outputs("reset_during");
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_idle_reset_outputs("reset_after");
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_latency();
    logic acc, p;
    logic [7:0] pw;
    logic [1:0] owa;
    cycle(0, 1'b1, 8'h3C, 1'b1, acc, p, pw, owa);
    n_checks++;
    if (acc !== 1'b1 || owa !== 2'd0) begin
      n_fail++; $display("FAIL latency_push: got acc=%b wa=%0d exp 1 0", acc, owa);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    #1;
    n_checks++;
    if (re[0] !== 1'b1 || ov[0] !== 1'b0 || lv[0] !== 3'd1) begin
      n_fail++; $display("FAIL latency_load: got re=%b ov=%b level=%0d exp 1 0 1", re[0], ov[0], lv[0]);
    end
    cycle(0, 1'b0, 8'h00, 1'b1, acc, p, pw, owa);
    n_checks++;
    if (ov[0] !== 1'b1 || od[0] !== 8'h3C || lv[0] !== 3'd1) begin
      n_fail++; $display("FAIL latency_out: got ov=%b data=%h level=%0d exp 1 3c 1", ov[0], od[0], lv[0]);
    end
    cycle(0, 1'b0, 8'h00, 1'b1, acc, p, pw, owa);
    n_checks++;
    if (p !== 1'b1 || pw !== 8'h3C || lv[0] !== 3'd0) begin
      n_fail++; $display("FAIL latency_pop: got pop=%b data=%h level=%0d exp 1 3c 0", p, pw, lv[0]);
    end
  endtask

  task automatic test_fill_full();
    logic acc, p;
    logic [7:0] pw;
    logic [1:0] owa;
    int n_acc = 0;
    logic [7:0] got[$];
    int k;
    for (int i = 1; i <= 6; i++) begin
      cycle(0, 1'b1, 8'(i), 1'b0, acc, p, pw, owa);
      if (acc) n_acc++;
    end
    n_checks++;
    if (n_acc != 5) begin
      n_fail++; $display("FAIL fill_accepted: got %0d exp 5", n_acc);
    end
    n_checks++;
    if (lv[0] !== 3'd5 || fu[0] !== 1'b1 || ir[0] !== 1'b0) begin
      n_fail++; $display("FAIL fill_flags: got level=%0d full=%b ready=%b exp 5 1 0", lv[0], fu[0], ir[0]);
    end
    // keep 0x06 offered until it is taken while draining
    k = 0;
    acc = 1'b0;
    while (got.size() < 6 && k < 30) begin
      cycle(0, !acc && n_acc < 6 ? 1'b1 : 1'b0, 8'h06, 1'b1, acc, p, pw, owa);
      if (acc) n_acc++;
      acc = (n_acc >= 6);
      if (p) got.push_back(pw);
      k++;
    end
    n_checks++;
    if (got.size() != 6) begin
      n_fail++; $display("FAIL fill_drain_count: got %0d exp 6", got.size());
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_checks++;
      if (got[i] !== 8'(i + 1)) begin
        n_fail++; $display("FAIL fill_drain_order[%0d]: got %h exp %h", i, got[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_pointer_wrap();
    logic acc, p, rdy;
    logic [7:0] pw, data;
    logic [1:0] owa;
    logic [7:0] sent[$];
    logic [7:0] got[$];
    int budget;
    for (int i = 0; i < 10; i++) begin
      data = 8'($urandom);
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 40) begin
        rdy = 1'($urandom_range(0, 1));
        cycle(1, 1'b1, data, rdy, acc, p, pw, owa);
        if (p) got.push_back(pw);
        budget++;
      end
      n_checks++;
      if (!acc) begin
        n_fail++; $display("FAIL wrap_push_timeout word %0d: got acc=0 exp 1", i);
      end else begin
        sent.push_back(data);
        n_checks++;
        if (owa !== 2'(i % 3)) begin
          n_fail++; $display("FAIL wrap_write_addr word %0d: got %0d exp %0d", i, owa, i % 3);
        end
      end
    end
    budget = 0;
    while (got.size() < sent.size() && budget < 30) begin
      cycle(1, 1'b0, 8'h00, 1'b1, acc, p, pw, owa);
      if (p) got.push_back(pw);
      budget++;
    end
    n_checks++;
    if (got.size() != 10) begin
      n_fail++; $display("FAIL wrap_count: got %0d exp 10", got.size());
    end
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      n_checks++;
      if (got[i] !== sent[i]) begin
        n_fail++; $display("FAIL wrap_order[%0d]: got %h exp %h", i, got[i], sent[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, p;
    logic [7:0] pw;
    logic [1:0] owa;
    int n_pop = 0;
    for (int i = 0; i < 3; i++) cycle(0, 1'b1, 8'(8'h40 + i), 1'b0, acc, p, pw, owa);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1'b1, 8'(8'h50 + i), 1'b1, acc, p, pw, owa);
      if (p && acc) n_pop++;
      n_checks++;
      if (lv[0] !== 3'd3 || af[0] !== 1'b1) begin
        n_fail++; $display("FAIL steady_level cycle %0d: got level=%0d afull=%b exp 3 1", i, lv[0], af[0]);
      end
    end
    n_checks++;
    if (n_pop != 20) begin
      n_fail++; $display("FAIL steady_throughput: got %0d exp 20", n_pop);
    end
    cycle(0, 1'b0, 8'h00, 1'b1, acc, p, pw, owa);
    n_checks++;
    if (lv[0] !== 3'd2 || af[0] !== 1'b0) begin
      n_fail++; $display("FAIL afull_fall: got level=%0d afull=%b exp 2 0", lv[0], af[0]);
    end
    cycle(0, 1'b1, 8'h77, 1'b0, acc, p, pw, owa);
    n_checks++;
    if (lv[0] !== 3'd3 || af[0] !== 1'b1) begin
      n_fail++; $display("FAIL afull_rise: got level=%0d afull=%b exp 3 1", lv[0], af[0]);
    end
    for (int i = 0; i < 8; i++) cycle(0, 1'b0, 8'h00, 1'b1, acc, p, pw, owa);
    n_checks++;
    if (em[0] !== 1'b1) begin
      n_fail++; $display("FAIL steady_drained: got empty=%b exp 1", em[0]);
    end
  endtask

  task automatic test_random();
    logic acc, p;
    logic [7:0] pw;
    logic [1:0] owa;
    for (int i = 0; i < 300; i++) begin
      cycle(0, 1'($urandom_range(0, 3) != 0), 8'($urandom),
            1'($urandom_range(0, 2) != 0), acc, p, pw, owa);
    end
    for (int i = 0; i < 8; i++) cycle(0, 1'b0, 8'h00, 1'b1, acc, p, pw, owa);
  endtask

  task automatic test_reset_mid_stream();
    logic acc, p;
    logic [7:0] pw;
    logic [1:0] owa;
    int budget;
    logic seen;
    for (int i = 0; i < 5; i++) cycle(0, 1'b1, 8'(8'h90 + i), 1'b0, acc, p, pw, owa);
    iv[0] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (ov[0] !== 1'b0 || lv[0] !== 3'd0 || em[0] !== 1'b1 || ra[0] !== 2'd0) begin
      n_fail++; $display("FAIL reset_mid: got ov=%b level=%0d empty=%b ra=%0d exp 0 0 1 0",
                         ov[0], lv[0], em[0], ra[0]);
    end
    model_reset();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, 1'b1, 8'hA5, 1'b1, acc, p, pw, owa);
    budget = 0;
    seen = 1'b0;
    while (!seen && budget < 5) begin
      cycle(0, 1'b0, 8'h00, 1'b1, acc, p, pw, owa);
      if (p) begin
        seen = 1'b1;
        n_checks++;
        if (pw !== 8'hA5) begin
          n_fail++; $display("FAIL reset_first_word: got %h exp a5", pw);
        end
      end
      budget++;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL reset_first_word_timeout: got no word exp a5");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_latency();
    test_fill_full();
    test_pointer_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
